mem_copy_ctrl: RTL and testbench
================================

# mem_copy_ctrl

Block-copy controller that sits directly upstream of the byte-wide `Memory` and drives its `addr`/`write`/`wrData` ports and consumes its `rdData`. On a `start` pulse it copies `len` words from `srcAddr` to `dstAddr` in ascending address order, one word at a time. It reports `busy` and a one-cycle `done`. It is the first bus master the memory gets in place of testbench-driven accesses.

## Interface
- `width`, 8: data word width; must match the memory's `width`.
- `addrSize`, 8: address width; must match the memory's `addrSize`. Also sets the width of `len`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `srcAddr`  in  addrSize  source base address; latched at accepted start.
- `dstAddr`  in  addrSize  destination base address; latched at accepted start.
- `len`  in  addrSize  word count; latched at accepted start.
- `busy`  out  1  high from the cycle after an accepted start until DONE is left.
- `done`  out  1  one-cycle completion pulse.
- `memAddr`  out  addrSize  to memory `addr`.
- `memWrite`  out  1  to memory `write`.
- `memWrData`  out  width  to memory `wrData`.
- `memRdData`  in  width  from memory `rdData`.
- `checksum`  out  width  running sum of copied words (see Configuration).

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE. All outputs are Moore outputs decoded from registered state.
- IDLE:
  - `start`=1 and `len`≠0: latch `srcAddr`, `dstAddr` and `len`; clear the index `i` and `checksum`; go to READ.
  - `start`=1 and `len`=0: go straight to DONE. No memory access occurs.
- READ: `memAddr`=src+i, `memWrite`=0. Go to WAIT.
- WAIT: `memAddr` holds src+i and `memWrite`=0. At the end of WAIT, capture `memRdData` into `dataReg`. Go to WRITE.
- WRITE: `memAddr`=dst+i, `memWrite`=1, `memWrData`=`dataReg`. At the end of the cycle, `i` increments.
  - If i+1 = len: go to DONE.
  - Otherwise: go to READ.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Address arithmetic is modulo 2^addrSize. src+i and dst+i wrap silently.
- Overlapping regions: the copy is strictly forward.
  - If dst lies in (src, src+len), already-written words are re-read. This "smear" is the defined behaviour, not an error.
- `start` while not in IDLE is ignored. It is not queued.
- Outside WRITE: `memWrite`=0 and `memWrData`=`dataReg`.

## Timing
- Memory contract: write on the rising edge when `write`=1; `rdData` is registered, valid one cycle after `addr` is presented.
- Each word costs 3 cycles (READ, WAIT, WRITE).
- Total latency from the accepted-start edge to `done` high is 3·len+1 cycles.
- `len`=0 gives `done` on the cycle after start.
- `busy`=1 in READ, WAIT, WRITE and DONE; `busy`=0 in IDLE.
- Reset values: state IDLE, `busy`=0, `done`=0, `memWrite`=0, `memAddr`=0, `memWrData`=0, `checksum`=0, `i`=0, `dataReg`=0.
- Reset mid-copy: the block returns to IDLE immediately and asynchronously. `memWrite` drops the same instant, and no further writes occur. A partially completed copy is left as-is.

## Configuration
- Macro: `MEM_COPY_CHECKSUM_EN`.
- Defined: `checksum` clears at an accepted start. At each WRITE edge it adds `dataReg` modulo 2^width. It holds its value after `done` until the next accepted start.
- Undefined: no adder is built and `checksum` is tied to 0. The port stays present so instantiations are identical in both builds.

## Structure
- Shared package `mem_copy_pkg`:
  - state encoding constants (IDLE=0, READ=1, WAIT=2, WRITE=3, DONE=4; 3 bits);
  - `CYCLES_PER_WORD`=3.
- No sub-module. The index counter, address adders and FSM are small enough to live in one module.

## Test plan
- Memory preloaded with Mem[10..13]=8'h11,22,33,44; start with src=10, dst=40, len=4 → Mem[40..43]=11,22,33,44; `done` exactly 13 cycles after start; checksum=8'hAA when the macro is defined, 0 otherwise.
- start with len=0 → `done` on the next cycle; `memWrite` never asserted; memory unchanged.
- src=254, dst=0, len=4 with Mem[254,255,0,1]=1,2,3,4 → copy wraps the source and ends with Mem[0..3]=1,2,1,2 (forward-copy smear).
- Mem[20..22]=5,6,7; copy src=20, dst=21, len=3 → Mem[21..23]=5,5,5.
- Second `start` pulse during READ of word 2 → ignored; single `done`; data identical to the undisturbed run.
- `rst` asserted during the WRITE of word 1 of a len=4 copy → `memWrite` low immediately; `busy`=0; only word 0 written; a fresh start then completes normally.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared definitions for the block-copy controller: FSM state encoding and
// per-word cycle cost.
package mem_copy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int CYCLES_PER_WORD = 3;

endpackage

// File: rtl/mem_copy_ctrl.sv
// Forward block-copy bus master for a registered-read byte memory.
// Optional running checksum of copied words enabled by `MEM_COPY_CHECKSUM_EN.
module mem_copy_ctrl
    import mem_copy_pkg::*;
#(
    parameter int width    = 8,
    parameter int addrSize = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [addrSize-1:0] srcAddr,
    input  logic [addrSize-1:0] dstAddr,
    input  logic [addrSize-1:0] len,
    output logic                busy,
    output logic                done,
    output logic [addrSize-1:0] memAddr,
    output logic                memWrite,
    output logic [width-1:0]    memWrData,
    input  logic [width-1:0]    memRdData,
    output logic [width-1:0]    checksum
);

    state_t              state_q, state_d;
    logic [addrSize-1:0] src_q, src_d;
    logic [addrSize-1:0] dst_q, dst_d;
    logic [addrSize-1:0] len_q, len_d;
    logic [addrSize-1:0] idx_q, idx_d;
    logic [width-1:0]    data_q, data_d;
    logic [addrSize-1:0] mem_addr_q, mem_addr_d;
    logic                mem_write_q, mem_write_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

`ifdef MEM_COPY_CHECKSUM_EN
    logic [width-1:0]    chk_q, chk_d;
    assign checksum = chk_q;
`else
    assign checksum = '0;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        data_d  = data_q;
`ifdef MEM_COPY_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        src_d   = srcAddr;
                        dst_d   = dstAddr;
                        len_d   = len;
                        idx_d   = '0;
`ifdef MEM_COPY_CHECKSUM_EN
                        chk_d   = '0;
`endif
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT: begin
                // Memory read data is valid here, one cycle after the address.
                data_d  = memRdData;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                idx_d   = idx_q + 1'b1;
`ifdef MEM_COPY_CHECKSUM_EN
                chk_d   = chk_q + data_q;
`endif
                state_d = ((idx_q + 1'b1) == len_q) ? ST_DONE : ST_READ;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register with it.
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        mem_write_d = (state_d == ST_WRITE);
        mem_addr_d  = mem_addr_q;
        if (state_d == ST_READ || state_d == ST_WAIT) begin
            mem_addr_d = src_d + idx_d;
        end else if (state_d == ST_WRITE) begin
            mem_addr_d = dst_d + idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef MEM_COPY_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign memAddr   = mem_addr_q;
    assign memWrite  = mem_write_q;
    assign memWrData = data_q;

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Directed bench for mem_copy_ctrl with a registered-read byte memory model.
module tb_mem_copy_ctrl;

`ifdef MEM_COPY_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] srcAddr = '0;
    logic [7:0] dstAddr = '0;
    logic [7:0] len = '0;
    logic       busy, done, memWrite;
    logic [7:0] memAddr, memWrData, memRdData, checksum;

    logic [7:0] mem [0:255];
    logic       tb_we = 1'b0;
    logic [7:0] tb_a = '0;
    logic [7:0] tb_d = '0;

    int n_checks = 0;
    int n_errors = 0;
    int lat, n_done;
    bit wrote;

    always #5 clk = ~clk;

    mem_copy_ctrl #(.width(8), .addrSize(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .srcAddr(srcAddr), .dstAddr(dstAddr), .len(len),
        .busy(busy), .done(done),
        .memAddr(memAddr), .memWrite(memWrite), .memWrData(memWrData),
        .memRdData(memRdData), .checksum(checksum)
    );

    // Byte memory: write on rising edge, registered read data.
    always @(posedge clk) begin
        if (memWrite) mem[memAddr] <= memWrData;
        else if (tb_we) mem[tb_a] <= tb_d;
        memRdData <= mem[memAddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_a = a; tb_d = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // mode 0: plain copy; 1: extra start during READ of word 2;
    // 2: reset asserted during WRITE of word 1, then return.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input int mode, output int lat_o, output int ndone_o,
                            output bit wrote_o);
        int n;
        @(negedge clk);
        srcAddr = s; dstAddr = d; len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1; lat_o = -1; ndone_o = 0; wrote_o = 1'b0;
        while (n <= 100) begin
            if (memWrite) wrote_o = 1'b1;
            if (done) begin
                ndone_o++;
                if (lat_o < 0) lat_o = n;
            end
            if (mode == 1 && n == 7) begin
                start = 1'b1; srcAddr = 8'h00;
            end else begin
                start = 1'b0;
            end
            if (mode == 2 && n == 6) begin
                check("pre_rst_write", memWrite, 1);
                rst = 1'b1;
                #1;
                check("rst_memwrite", memWrite, 0);
                check("rst_busy", busy, 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (lat_o >= 0 && n >= lat_o + 5) break;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_busy0", busy, 0);
        check("rst_done0", done, 0);
        check("rst_write0", memWrite, 0);
        check("rst_addr0", memAddr, 0);
        check("rst_wrdata0", memWrData, 0);
        check("rst_chk0", checksum, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic copy
        poke(8'd10, 8'h11); poke(8'd11, 8'h22); poke(8'd12, 8'h33); poke(8'd13, 8'h44);
        for (int k = 40; k < 44; k++) poke(k[7:0], 8'h00);
        run_copy(8'd10, 8'd40, 8'd4, 0, lat, n_done, wrote);
        check("t1_lat", lat, 13);
        check("t1_ndone", n_done, 1);
        check("t1_m40", mem[40], 8'h11);
        check("t1_m41", mem[41], 8'h22);
        check("t1_m42", mem[42], 8'h33);
        check("t1_m43", mem[43], 8'h44);
        check("t1_chk", checksum, CHK_EN ? 8'hAA : 8'h00);

        // Zero-length request
        poke(8'd50, 8'h5A);
        run_copy(8'd5, 8'd50, 8'd0, 0, lat, n_done, wrote);
        check("t2_lat", lat, 1);
        check("t2_nowrite", wrote, 0);
        check("t2_m50", mem[50], 8'h5A);
        check("t2_chk_hold", checksum, CHK_EN ? 8'hAA : 8'h00);

        // Source wrap with overlapping smear
        poke(8'd254, 8'd1); poke(8'd255, 8'd2); poke(8'd0, 8'd3); poke(8'd1, 8'd4);
        run_copy(8'd254, 8'd0, 8'd4, 0, lat, n_done, wrote);
        check("t3_m0", mem[0], 8'd1);
        check("t3_m1", mem[1], 8'd2);
        check("t3_m2", mem[2], 8'd1);
        check("t3_m3", mem[3], 8'd2);
        check("t3_chk", checksum, CHK_EN ? 8'd6 : 8'd0);

        // dst = src+1 smear
        poke(8'd20, 8'd5); poke(8'd21, 8'd6); poke(8'd22, 8'd7); poke(8'd23, 8'd0);
        run_copy(8'd20, 8'd21, 8'd3, 0, lat, n_done, wrote);
        check("t4_lat", lat, 10);
        check("t4_m21", mem[21], 8'd5);
        check("t4_m22", mem[22], 8'd5);
        check("t4_m23", mem[23], 8'd5);
        check("t4_chk", checksum, CHK_EN ? 8'd15 : 8'd0);

        // Start while busy is ignored
        for (int k = 60; k < 64; k++) poke(k[7:0], 8'h00);
        run_copy(8'd10, 8'd60, 8'd4, 1, lat, n_done, wrote);
        check("t5_lat", lat, 13);
        check("t5_ndone", n_done, 1);
        check("t5_m60", mem[60], 8'h11);
        check("t5_m61", mem[61], 8'h22);
        check("t5_m62", mem[62], 8'h33);
        check("t5_m63", mem[63], 8'h44);

        // Reset mid-copy, then a fresh copy
        for (int k = 80; k < 84; k++) poke(k[7:0], 8'hEE);
        run_copy(8'd10, 8'd80, 8'd4, 2, lat, n_done, wrote);
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_m80", mem[80], 8'h11);
        check("t6_m81", mem[81], 8'hEE);
        check("t6_m82", mem[82], 8'hEE);
        run_copy(8'd10, 8'd80, 8'd4, 0, lat, n_done, wrote);
        check("t6b_lat", lat, 13);
        check("t6b_m81", mem[81], 8'h22);
        check("t6b_m83", mem[83], 8'h44);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
